// File: rtl/project3_nios2_oci_dct_packer.sv
// OCI debug-trace compression packer: shifts 2-bit trace codes into a 30-bit
// word and hands the word off with a 4-bit entry count over valid/ready.
// Optional feature macro: DCT_PACKER_TEST_ENDING_EN (adds test_ending /
// test_has_ended end-of-test drain handshake).
module project3_nios2_oci_dct_packer #(
    parameter int unsigned MAX_COUNT = 15,
    parameter int unsigned STALL_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               code_valid,
    input  logic [1:0]         code,
    output logic               code_ready,
    input  logic               flush,
    output logic               dct_valid,
    input  logic               dct_ready,
    output logic [29:0]        dct_buffer,
    output logic [3:0]         dct_count,
`ifdef DCT_PACKER_TEST_ENDING_EN
    input  logic               test_ending,
    output logic               test_has_ended,
`endif
    output logic [STALL_W-1:0] stall_count
);

    localparam logic [3:0] MAX_C = 4'(MAX_COUNT);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [29:0] buf_nxt;
    logic [3:0]  count_nxt;
    logic        accept;
    logic        flush_eff;
    logic        intake_open;

`ifdef DCT_PACKER_TEST_ENDING_EN
    logic te_q;
    logic ending_q;
    logic te_rise;

    assign te_rise     = test_ending & ~te_q;
    assign flush_eff   = flush | te_rise;
    assign intake_open = ~ending_q;

    // Edge detect on test_ending and latch the end-of-test condition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            te_q           <= 1'b0;
            ending_q       <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            te_q <= test_ending;
            if (te_rise)
                ending_q <= 1'b1;
            // Sticky once ending is requested and nothing is left to drain
            if ((ending_q | te_rise) && state_nxt == FILL && count_nxt == 4'd0)
                test_has_ended <= 1'b1;
        end
    end
`else
    assign flush_eff   = flush;
    assign intake_open = 1'b1;
`endif

    assign code_ready = (state == FILL) & intake_open;
    assign accept     = code_valid & code_ready;
    assign dct_valid  = (state == HOLD);

    // Next-state and next word: a same-cycle accept lands before any flush closes the word
    always_comb begin
        state_nxt = state;
        buf_nxt   = dct_buffer;
        count_nxt = dct_count;
        case (state)
            FILL: begin
                if (accept) begin
                    buf_nxt   = {dct_buffer[27:0], code};
                    count_nxt = dct_count + 4'd1;
                end
                if ((accept && count_nxt == MAX_C) || (flush_eff && count_nxt != 4'd0))
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (dct_ready) begin
                    state_nxt = FILL;
                    buf_nxt   = '0;
                    count_nxt = '0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State and packed-word registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            state      <= state_nxt;
            dct_buffer <= buf_nxt;
            dct_count  <= count_nxt;
        end
    end

    // Saturating count of cycles a code was offered but refused
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (code_valid && !code_ready && stall_count != '1)
            stall_count <= stall_count + STALL_W'(1);
    end

endmodule
